// File: rtl/panel_input_conditioner_if.sv
// Front-panel signal bundle: raw switch/key inputs toward the conditioner and
// the clean, debounced signals it hands to the machine top level.
interface panel_input_conditioner_if;
   logic       key_raw;
   logic [2:0] sw_raw;     // {SW_choose, SW1, SW2}
   logic [7:0] d_raw;
   logic       A1;
   logic       A1_level;
   logic       SW_choose;
   logic       SW1;
   logic       SW2;
   logic [7:0] D;
   logic       sw_change;

   modport master (
      output key_raw, sw_raw, d_raw,
      input  A1, A1_level, SW_choose, SW1, SW2, D, sw_change
   );

   modport slave (
      input  key_raw, sw_raw, d_raw,
      output A1, A1_level, SW_choose, SW1, SW2, D, sw_change
   );
endinterface

// File: rtl/panel_input_conditioner.sv
// Front-panel input conditioner: 2-flop synchronisers, a key press FSM that emits
// one A1 pulse per debounced press, and vector debouncers for the switch groups.
module panel_input_conditioner_vdeb #(
   parameter int             W          = 8,
   parameter int             DEB_CYCLES = 4,
   parameter logic [W-1:0]   CHG_MASK   = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] raw_i,
   output logic [W-1:0] val_o,
   output logic         chg_o
);
   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

   logic [W-1:0]  s1_q, s2_q, val_q, cand_q;
   logic [CW-1:0] cnt_q;
   logic          chg_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q   <= '0;
         s2_q   <= '0;
         val_q  <= '0;
         cand_q <= '0;
         cnt_q  <= '0;
         chg_q  <= 1'b0;
      end else begin
         s1_q  <= raw_i;
         s2_q  <= s1_q;
         chg_q <= 1'b0;
         if (s2_q == val_q) begin
            cnt_q  <= '0;
            cand_q <= val_q;
         end else if (s2_q != cand_q) begin
            // any toggle inside the group restarts the stability window
            cand_q <= s2_q;
            cnt_q  <= '0;
         end else if (cnt_q == CNT_MAX) begin
            val_q <= cand_q;
            cnt_q <= '0;
            chg_q <= |((cand_q ^ val_q) & CHG_MASK);
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign val_o = val_q;
   assign chg_o = chg_q;
endmodule

module panel_input_conditioner #(
   parameter int DEB_CYCLES     = 4,
   parameter bit KEY_ACTIVE_LOW = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   panel_input_conditioner_if.slave      pif
);
   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
   localparam logic KEY_REL = KEY_ACTIVE_LOW;   // raw level of a released key

   typedef enum logic [1:0] {IDLE, CONFIRM, PRESSED, RELEASE} key_st_e;

   key_st_e       st_q;
   logic [CW-1:0] kcnt_q;
   logic          ks1_q, ks2_q;
   logic          a1_q, lvl_q;
   logic          k;

   assign k = KEY_ACTIVE_LOW ? ~ks2_q : ks2_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ks1_q  <= KEY_REL;
         ks2_q  <= KEY_REL;
         st_q   <= IDLE;
         kcnt_q <= '0;
         a1_q   <= 1'b0;
         lvl_q  <= 1'b0;
      end else begin
         ks1_q <= pif.key_raw;
         ks2_q <= ks1_q;
         a1_q  <= 1'b0;
         case (st_q)
            IDLE: begin
               kcnt_q <= '0;
               if (k) st_q <= CONFIRM;
            end
            CONFIRM: begin
               if (!k) begin
                  st_q   <= IDLE;
                  kcnt_q <= '0;
               end else if (kcnt_q == CNT_MAX) begin
                  st_q   <= PRESSED;
                  kcnt_q <= '0;
                  a1_q   <= 1'b1;
                  lvl_q  <= 1'b1;
               end else begin
                  kcnt_q <= kcnt_q + 1'b1;
               end
            end
            PRESSED: begin
               kcnt_q <= '0;
               if (!k) st_q <= RELEASE;
            end
            RELEASE: begin
               // bounce during release returns to PRESSED without a new pulse
               if (k) begin
                  st_q   <= PRESSED;
                  kcnt_q <= '0;
               end else if (kcnt_q == CNT_MAX) begin
                  st_q   <= IDLE;
                  kcnt_q <= '0;
                  lvl_q  <= 1'b0;
               end else begin
                  kcnt_q <= kcnt_q + 1'b1;
               end
            end
            default: begin
               st_q   <= IDLE;
               kcnt_q <= '0;
               lvl_q  <= 1'b0;
            end
         endcase
      end
   end

   logic [2:0] sw_val;
   logic [7:0] d_val;
   logic       sw_chg;
   logic       d_chg_unused;

   // only SW1/SW2 count as a mode change; SW_choose alone is silent
   panel_input_conditioner_vdeb #(
      .W(3), .DEB_CYCLES(DEB_CYCLES), .CHG_MASK(3'b011)
   ) u_sw (
      .clk(clk), .rst(rst), .raw_i(pif.sw_raw), .val_o(sw_val), .chg_o(sw_chg)
   );

   panel_input_conditioner_vdeb #(
      .W(8), .DEB_CYCLES(DEB_CYCLES), .CHG_MASK(8'h00)
   ) u_d (
      .clk(clk), .rst(rst), .raw_i(pif.d_raw), .val_o(d_val), .chg_o(d_chg_unused)
   );

   assign pif.A1        = a1_q;
   assign pif.A1_level  = lvl_q;
   assign pif.SW_choose = sw_val[2];
   assign pif.SW1       = sw_val[1];
   assign pif.SW2       = sw_val[0];
   assign pif.D         = d_val;
   assign pif.sw_change = sw_chg;
endmodule
